cbus_write_buffer: RTL and testbench
====================================

Name: cbus_write_buffer

Overview:
- Sits between the DCache memory-side port (creq/cresp) and the CBus arbiter's data-side input.
- Absorbs dirty-line writeback bursts (and single-beat uncached stores) into a small FIFO and acknowledges them at full rate, so the following refill read is not blocked.
- Forwards reads straight through when no buffered write targets the same line. Drains buffered writes to memory when the downstream port is idle.

Parameters:
DEPTH, 2, number of buffered write bursts (power of two, >=1)
MAX_BEATS, 16, max beats per buffered burst (line words)
LINE_BYTES, 128, address-match granularity for read/write conflict

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
creq  in  cbus_req_t  upstream request from DCache
cresp  out  cbus_resp_t  upstream response to DCache
oreq  out  cbus_req_t  downstream request to arbiter
oresp  in  cbus_resp_t  downstream response from arbiter

Behaviour:
- Reset (reset=0, async): all entries invalid, head/tail/counters 0, FSM IDLE, cresp and oreq all-zero. A partially captured or partially drained burst is discarded.
- CBus rule (both sides):
  - The master holds valid/addr/size/strobe/len/burst stable from the first beat to the beat with last.
  - The slave pulses ready once per accepted beat and asserts last together with ready on beat len (len = beats-1).
- Write capture (creq.valid & creq.is_write):
  - Entry free at tail: cresp.ready=1 each cycle, data stored at beat index; header latched on beat 0; cresp.last=1 on beat creq.len.
  - Zero-cycle latency: ready is combinational on valid.
  - After last: entry valid, tail++ (mod DEPTH).
  - FIFO full: cresp.ready=0 until an entry frees.
  - Capture runs concurrently with DRAIN.
  - creq.len+1 > MAX_BEATS is illegal; simulation assertion.
- Read (creq.valid & ~is_write): conflict if any valid entry has equal addr[63:log2(LINE_BYTES)].
- FSM (downstream side):
  - IDLE:
    - Read pending and no conflict -> FWD_READ.
    - Else any valid entry -> DRAIN (oldest at head).
    - Read priority over drain when both are eligible.
  - FWD_READ:
    - oreq = creq; cresp = oresp (combinational pass-through).
    - On oresp.ready & oresp.last -> IDLE.
  - DRAIN:
    - oreq = head entry header, is_write=1, data = entry.data[beat].
    - beat++ on oresp.ready.
    - On oresp.ready & oresp.last: entry invalid, head++, beat=0, -> IDLE.
    - Never preempted mid-burst.
- Conflicting read: stalls (cresp.ready=0) until all matching entries drain, then forwards. The read therefore observes the written data.
- oreq.valid=0 in IDLE. No combinational path from oresp to oreq.
- Simultaneous free and capture in the same cycle on a full FIFO: capture of the new burst starts the following cycle (full computed from registered state).

Decomposition:
- Shared package (common):
  - WB_DEPTH, WB_LINE_BYTES
  - wb_entry_t {valid, addr, size, strobe, len, burst, data[MAX_BEATS]}
  - wb_state_t {IDLE, FWD_READ, DRAIN}
- Sub-module cbus_wb_fifo:
  - Entry storage, head/tail pointers, capture beat counter, full/empty.
  - Conflict-match vector over all entries.
- cbus_write_buffer keeps the downstream FSM and muxing.

Test Plan:
- Writeback 16 beats addr 0x8000_0080, data i: cresp.ready 16 consecutive cycles, last on 16th; then DRAIN emits 16 beats, addr 0x8000_0080, data 0..15, oresp.last frees entry.
- Writeback 0x8000_0080 then immediate read 0x8000_1000: read forwarded first; drain oreq.valid only after read's oresp.last; both complete correctly.
- Writeback 0x8000_0080 (data 0xAA..) then read 0x8000_00C0 (same line): cresp.ready=0 until drain last; read then returns 0xAA.. from memory model.
- oresp.ready held 0, three writebacks: first two accepted (DEPTH=2), third sees cresp.ready=0; release ready -> third accepted after first drains.
- Uncached store len=0, addr 0x4060_0004, strobe 0x0F: one-beat capture with ready&last same cycle; one-beat drain with identical fields.
- Reset asserted mid-DRAIN beat 7: oreq/cresp zero immediately; after release FIFO empty, no further beats issued.

Source files
------------

// File: rtl/cbus_write_buffer_pkg.sv
// cbus_write_buffer_pkg
// Shared types and constants for the CBus write buffer:
//   cbus_req_t / cbus_resp_t : one CBus request / response beat
//   wb_entry_t               : one buffered write burst (header + line data)
//   wb_state_t               : downstream FSM state
package cbus_write_buffer_pkg;

    localparam int WB_DEPTH      = 2;    // buffered write bursts
    localparam int WB_MAX_BEATS  = 16;   // beats per burst (line words)
    localparam int WB_LINE_BYTES = 128;  // read/write conflict granularity
    localparam int WB_BEAT_W     = (WB_MAX_BEATS > 1) ? $clog2(WB_MAX_BEATS) : 1;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;    // beats - 1
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef struct packed {
        logic                             valid;
        logic [63:0]                      addr;
        logic [2:0]                       size;
        logic [7:0]                       strobe;
        logic [7:0]                       len;
        logic [1:0]                       burst;
        logic [WB_MAX_BEATS-1:0][63:0]    data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_FWD_READ = 2'd1,
        WB_DRAIN    = 2'd2
    } wb_state_t;

endpackage

// File: rtl/cbus_wb_fifo.sv
// cbus_wb_fifo
// Storage for buffered write bursts. Captures write beats from the upstream
// request at full rate into the entry at tail, and frees the entry at head when
// the downstream drain completes. Also reports which valid entries hold the
// same line as the current upstream address (read/write conflict detection).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   creq_i         : upstream request (captured when valid & is_write)
//   cap_ready_o    : beat accepted this cycle
//   cap_last_o     : accepted beat is the final beat of the burst
//   free_i         : release the head entry (drain finished)
//   head_entry_o   : oldest entry (valid bit set when anything is buffered)
//   match_o        : per-entry valid & same-line match against creq_i.addr
module cbus_wb_fifo
    import cbus_write_buffer_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int MAX_BEATS  = WB_MAX_BEATS,
    parameter int LINE_BYTES = WB_LINE_BYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cbus_req_t        creq_i,
    output logic             cap_ready_o,
    output logic             cap_last_o,
    input  logic             free_i,
    output wb_entry_t        head_entry_o,
    output logic [DEPTH-1:0] match_o
);

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LINE_LSB = $clog2(LINE_BYTES);

    wb_entry_t            entries_q [DEPTH];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [WB_BEAT_W-1:0] cap_beat_q;
    logic                 cap_valid;
    logic                 full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cap_valid = creq_i.valid & creq_i.is_write;

    // Full looks only at registered state: an entry freed this cycle becomes
    // usable for capture on the next cycle.
    assign full        = entries_q[tail_q].valid;
    assign cap_ready_o = cap_valid & ~full;
    assign cap_last_o  = cap_ready_o & ({{(8 - WB_BEAT_W){1'b0}}, cap_beat_q} == creq_i.len);

    // Entries become valid in tail order and free in head order, so head is
    // valid exactly when any entry is.
    assign head_entry_o = entries_q[head_q];

    always_comb begin
        match_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = entries_q[i].valid &&
                         (entries_q[i].addr[63:LINE_LSB] == creq_i.addr[63:LINE_LSB]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            cap_beat_q <= '0;
        end else begin
            if (cap_ready_o) begin
                entries_q[tail_q].data[cap_beat_q] <= creq_i.data;
                if (cap_beat_q == '0) begin
                    entries_q[tail_q].addr   <= creq_i.addr;
                    entries_q[tail_q].size   <= creq_i.size;
                    entries_q[tail_q].strobe <= creq_i.strobe;
                    entries_q[tail_q].len    <= creq_i.len;
                    entries_q[tail_q].burst  <= creq_i.burst;
                end
                if (cap_last_o) begin
                    entries_q[tail_q].valid <= 1'b1;
                    tail_q                  <= ptr_inc(tail_q);
                    cap_beat_q              <= '0;
                end else begin
                    cap_beat_q <= cap_beat_q + 1'b1;
                end
            end
            if (free_i) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= ptr_inc(head_q);
            end
        end
    end

    // A burst longer than one line cannot be stored.
    assert property (@(posedge clk) disable iff (!rst_n)
        cap_valid |-> ({24'd0, creq_i.len} < 32'(MAX_BEATS)));

endmodule

// File: rtl/cbus_write_buffer.sv
// cbus_write_buffer
// Write buffer between the DCache memory port and the CBus arbiter. Writes are
// acknowledged at full rate into cbus_wb_fifo; reads are forwarded downstream
// unless they hit a buffered line, in which case they wait until those writes
// have drained. Buffered writes drain whenever the downstream port is idle.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   creq / cresp : upstream request / response (DCache side)
//   oreq / oresp : downstream request / response (arbiter side)
//   dbg_state_o  : current downstream FSM state
//
// Handshake (both sides): the master holds valid/addr/size/strobe/len/burst
// stable from the first beat through the beat with last; the slave pulses
// ready once per accepted beat and raises last together with ready on beat len.
module cbus_write_buffer
    import cbus_write_buffer_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int MAX_BEATS  = WB_MAX_BEATS,
    parameter int LINE_BYTES = WB_LINE_BYTES
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output wb_state_t  dbg_state_o
);

    wb_state_t            state_q;
    logic [WB_BEAT_W-1:0] drain_beat_q;

    logic             cap_ready;
    logic             cap_last;
    logic             drain_free;
    logic             read_pend;
    logic             conflict;
    wb_entry_t        head_entry;
    logic [DEPTH-1:0] match;

    cbus_wb_fifo #(
        .DEPTH      (DEPTH),
        .MAX_BEATS  (MAX_BEATS),
        .LINE_BYTES (LINE_BYTES)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (reset),
        .creq_i       (creq),
        .cap_ready_o  (cap_ready),
        .cap_last_o   (cap_last),
        .free_i       (drain_free),
        .head_entry_o (head_entry),
        .match_o      (match)
    );

    assign read_pend   = creq.valid & ~creq.is_write;
    assign conflict    = |match;
    assign drain_free  = (state_q == WB_DRAIN) & oresp.ready & oresp.last;
    assign dbg_state_o = state_q;

    // Downstream FSM. A read wins over draining when both are eligible; a
    // drain, once started, runs to its last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WB_IDLE;
            drain_beat_q <= '0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    if (read_pend && !conflict) begin
                        state_q <= WB_FWD_READ;
                    end else if (head_entry.valid) begin
                        state_q <= WB_DRAIN;
                    end
                end
                WB_FWD_READ: begin
                    if (oresp.ready && oresp.last) begin
                        state_q <= WB_IDLE;
                    end
                end
                WB_DRAIN: begin
                    if (oresp.ready) begin
                        if (oresp.last) begin
                            drain_beat_q <= '0;
                            state_q      <= WB_IDLE;
                        end else begin
                            drain_beat_q <= drain_beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end

    // oreq depends only on state, buffered entries and creq, never on oresp.
    always_comb begin
        oreq  = '0;
        cresp = '0;
        case (state_q)
            WB_FWD_READ: begin
                oreq  = creq;
                cresp = oresp;
            end
            WB_DRAIN: begin
                oreq.valid    = 1'b1;
                oreq.is_write = 1'b1;
                oreq.addr     = head_entry.addr;
                oreq.size     = head_entry.size;
                oreq.strobe   = head_entry.strobe;
                oreq.len      = head_entry.len;
                oreq.burst    = head_entry.burst;
                oreq.data     = head_entry.data[drain_beat_q];
            end
            default: ;
        endcase
        // Write acknowledges come from the capture side regardless of state.
        if (creq.valid && creq.is_write) begin
            cresp.ready = cap_ready;
            cresp.last  = cap_last;
            cresp.data  = '0;
        end
        if (!reset) begin
            oreq  = '0;
            cresp = '0;
        end
    end

endmodule

// File: tb/tb_cbus_write_buffer.sv
module tb_cbus_write_buffer;
    import cbus_write_buffer_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    wb_state_t  dbg_state;

    always #5 clk = ~clk;

    cbus_write_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .creq        (creq),
        .cresp       (cresp),
        .oreq        (oreq),
        .oresp       (oresp),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    localparam int DSW = 150;  // {wr, addr, data, size, strobe, len, burst}
    logic [DSW-1:0] exp_q[$];     // expected downstream beats, in order
    logic [64:0]    exp_rd_q[$];  // expected upstream read beats {last, data}
    int checks = 0;
    int errors = 0;

    logic [63:0] mem [logic [63:0]];
    logic        slave_en;
    int          slave_budget;   // -1: unlimited
    int          slave_beat;

    function automatic logic [63:0] mem_default(input logic [63:0] a);
        return {32'h5EED_0000, a[31:0]};
    endfunction

    task automatic check(input string name, input logic [DSW-1:0] act, input logic [DSW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [7:0] strobe, input logic [1:0] burst, input logic [63:0] base,
                           input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            exp_q.push_back({1'b1, addr, base + 64'(i), size, strobe, len, burst});
        end
    endtask

    task automatic push_rd(input logic [63:0] addr, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back({1'b0, addr, 64'd0, 3'd3, 8'hFF, len, 2'b01});
        end
    endtask

    // ---------------- downstream memory slave ----------------
    initial begin
        logic [63:0] a;
        oresp      = '0;
        slave_beat = 0;
        forever begin
            @(posedge clk);
            #2;
            oresp = '0;
            if (!reset) begin
                slave_beat = 0;
            end else if (slave_en && slave_budget != 0 && oreq.valid) begin
                a           = oreq.addr + 64'(slave_beat) * 64'd8;
                oresp.ready = 1'b1;
                oresp.last  = (slave_beat == int'(oreq.len));
                if (oreq.is_write) begin
                    mem[a] = oreq.data;
                end else begin
                    oresp.data = mem.exists(a) ? mem[a] : mem_default(a);
                end
                slave_beat = oresp.last ? 0 : slave_beat + 1;
                if (slave_budget > 0) slave_budget--;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [DSW-1:0] got;
        logic [64:0]    rgot;
        forever begin
            @(negedge clk);
            if (reset && oreq.valid && oresp.ready) begin
                got = {oreq.is_write, oreq.addr, oreq.data, oreq.size, oreq.strobe, oreq.len, oreq.burst};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ds_unexpected: got %0h expected none", got);
                end else begin
                    check("ds_beat", got, exp_q.pop_front());
                end
            end
            if (reset && creq.valid && !creq.is_write && cresp.ready) begin
                rgot = {cresp.last, cresp.data};
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %0h expected none", rgot);
                end else begin
                    check("rd_beat", DSW'(rgot), DSW'(exp_rd_q.pop_front()));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [7:0] strobe, input logic [1:0] burst, input logic [63:0] base,
                            output int stall);
        int beat;
        int cyc;
        beat  = 0;
        cyc   = 0;
        stall = 0;
        creq          = '0;
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.addr     = addr;
        creq.size     = size;
        creq.strobe   = strobe;
        creq.len      = len;
        creq.burst    = burst;
        creq.data     = base;
        while (beat <= int'(len) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cresp.ready) begin
                check("wr_last", DSW'(cresp.last), DSW'(beat == int'(len)));
                beat++;
                @(posedge clk);
                #1;
                if (beat <= int'(len)) creq.data = base + 64'(beat);
            end else begin
                stall++;
                @(posedge clk);
                #1;
            end
        end
        if (beat <= int'(len)) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: got %0d beats expected %0d", beat, int'(len) + 1);
        end
        creq = '0;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, output int stall);
        int beat;
        int cyc;
        beat  = 0;
        cyc   = 0;
        stall = 0;
        creq        = '0;
        creq.valid  = 1'b1;
        creq.addr   = addr;
        creq.size   = 3'd3;
        creq.strobe = 8'hFF;
        creq.len    = len;
        creq.burst  = 2'b01;
        while (beat <= int'(len) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cresp.ready) beat++;
            else             stall++;
            @(posedge clk);
            #1;
        end
        if (beat <= int'(len)) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout: got %0d beats expected %0d", beat, int'(len) + 1);
        end
        creq = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_rd_q.size() != 0 || dbg_state != WB_IDLE) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, DSW'(n < 2000), DSW'(1'b1));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int st;
        int st_c;
        int n;
        creq         = '0;
        reset        = 1'b0;
        slave_en     = 1'b1;
        slave_budget = -1;

        repeat (2) @(negedge clk);
        check("rst_oreq", DSW'(oreq), '0);
        check("rst_cresp", DSW'(cresp), '0);
        check("rst_state", DSW'(dbg_state), DSW'(WB_IDLE));
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: 16-beat writeback, data = beat index, then drain
        push_wr(64'h8000_0080, 8'd15, 3'd3, 8'hFF, 2'b01, 64'd0, 16);
        do_write(64'h8000_0080, 8'd15, 3'd3, 8'hFF, 2'b01, 64'd0, st);
        check("wb_full_rate", DSW'(st), '0);
        wait_idle("t1_done");

        // 2: writeback then non-conflicting read: read forwarded first
        push_rd(64'h8000_1000, 8'd15);
        for (int k = 0; k < 16; k++) begin
            exp_rd_q.push_back({(k == 15), 32'h5EED_0000, 32'h8000_1000 + 32'(k * 8)});
        end
        push_wr(64'h8000_0080, 8'd15, 3'd3, 8'hFF, 2'b01, 64'h2200_0000_0000_0000, 16);
        do_write(64'h8000_0080, 8'd15, 3'd3, 8'hFF, 2'b01, 64'h2200_0000_0000_0000, st);
        do_read(64'h8000_1000, 8'd15, st);
        wait_idle("t2_done");

        // 3: writeback then same-line read: read waits for drain, sees new data
        push_wr(64'h8000_0080, 8'd15, 3'd3, 8'hFF, 2'b01, 64'hAAAA_AAAA_AAAA_AA00, 16);
        push_rd(64'h8000_00C0, 8'd7);
        for (int k = 0; k < 8; k++) begin
            exp_rd_q.push_back({(k == 7), 64'hAAAA_AAAA_AAAA_AA08 + 64'(k)});
        end
        do_write(64'h8000_0080, 8'd15, 3'd3, 8'hFF, 2'b01, 64'hAAAA_AAAA_AAAA_AA00, st);
        do_read(64'h8000_00C0, 8'd7, st);
        check("conflict_stall", DSW'(st >= 16), DSW'(1'b1));
        wait_idle("t3_done");

        // 4: downstream stalled, three writebacks: third waits for a free entry
        slave_en = 1'b0;
        push_wr(64'h8000_0000, 8'd3, 3'd3, 8'hFF, 2'b01, 64'h3100, 4);
        push_wr(64'h8000_0100, 8'd3, 3'd3, 8'hFF, 2'b01, 64'h3200, 4);
        push_wr(64'h8000_0200, 8'd3, 3'd3, 8'hFF, 2'b01, 64'h3300, 4);
        do_write(64'h8000_0000, 8'd3, 3'd3, 8'hFF, 2'b01, 64'h3100, st);
        check("full_a_stall", DSW'(st), '0);
        do_write(64'h8000_0100, 8'd3, 3'd3, 8'hFF, 2'b01, 64'h3200, st);
        check("full_b_stall", DSW'(st), '0);
        fork
            do_write(64'h8000_0200, 8'd3, 3'd3, 8'hFF, 2'b01, 64'h3300, st_c);
            begin
                repeat (12) @(negedge clk);
                check("full_no_ready", DSW'(cresp.ready), '0);
                check("full_head", DSW'({oreq.valid, oreq.addr}), DSW'({1'b1, 64'h8000_0000}));
                slave_en = 1'b1;
            end
        join
        check("full_c_stall", DSW'(st_c >= 12), DSW'(1'b1));
        wait_idle("t4_done");

        // 5: uncached single-beat store
        push_wr(64'h4060_0004, 8'd0, 3'd2, 8'h0F, 2'b00, 64'h1122_3344_5566_7788, 1);
        do_write(64'h4060_0004, 8'd0, 3'd2, 8'h0F, 2'b00, 64'h1122_3344_5566_7788, st);
        check("single_stall", DSW'(st), '0);
        wait_idle("t5_done");

        // 6: reset while the drain presents beat 7
        slave_budget = 7;
        push_wr(64'h8000_0800, 8'd15, 3'd3, 8'hFF, 2'b01, 64'h6000, 7);
        do_write(64'h8000_0800, 8'd15, 3'd3, 8'hFF, 2'b01, 64'h6000, st);
        n = 0;
        while (!(slave_budget == 0 && exp_q.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_beat7", DSW'(n < 200), DSW'(1'b1));
        @(negedge clk);
        check("drain_beat7", DSW'({oreq.valid, oreq.data}), DSW'({1'b1, 64'h6007}));
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_oreq", DSW'(oreq), '0);
        check("mid_rst_cresp", DSW'(cresp), '0);
        check("mid_rst_state", DSW'(dbg_state), DSW'(WB_IDLE));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        slave_budget = -1;
        repeat (30) @(negedge clk);
        check("post_rst_state", DSW'(dbg_state), DSW'(WB_IDLE));
        check("post_rst_oreq_valid", DSW'(oreq.valid), '0);
        check("exp_q_empty", DSW'(exp_q.size()), '0);
        check("exp_rd_q_empty", DSW'(exp_rd_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
